// File: rtl/clk2strobe_fifo_pkg.sv
// Shared types and helpers for the sub_clk-to-strobe event path.
package clk2strobe_fifo_pkg;

  // Data width of the default configuration; the event record below matches it.
  localparam int DEFAULT_DW = 8;

  // One queued event: edge direction plus the data word sampled with it.
  typedef struct packed {
    logic                  rise;
    logic [DEFAULT_DW-1:0] data;
  } evt_t;

  // Ceiling log2 usable in constant expressions (port widths, localparams).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/clk2strobe_fifo_evt_fifo.sv
// First-word-fall-through FIFO of event records with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module evt_fifo
  import clk2strobe_fifo_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [W-1:0]          head,
  output logic                  empty,
  output logic                  full,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is forced to zero when empty so stale storage never shows on the outputs.
  assign head = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge mclk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/clk2strobe_fifo.sv
// Turns level changes of `in`, sampled on rising edges of the oversampled
// sub_clk, into one-cycle strobes and queued {rise, data} event records.
module clk2strobe_fifo
  import clk2strobe_fifo_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  sub_clk,
  input  logic                  in,
  input  logic [DW-1:0]         data,
  output logic                  rise_stb,
  output logic                  fall_stb,
  output logic                  level,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic                  evt_rise,
  output logic [DW-1:0]         evt_data,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  logic          prev_sub;
  logic          prev_sub_;
  logic          sub_r;
  logic          changed;
  logic          pop;
  logic          drop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [DW:0]   head;

  // sub_r marks the single cycle right after sub_clk is first seen high.
  assign sub_r   = ~prev_sub_ & prev_sub;
  assign changed = sub_r & (in != level);
  assign pop     = evt_valid & evt_ready;
  assign drop    = changed & fifo_full & ~pop;

  assign evt_valid = ~fifo_empty;
  assign evt_rise  = head[DW];
  assign evt_data  = head[DW-1:0];

  // Two-stage history of sub_clk; both start high so reset never looks like an edge.
  always_ff @(posedge mclk) begin
    if (reset) begin
      prev_sub  <= 1'b1;
      prev_sub_ <= 1'b1;
    end else begin
      prev_sub  <= sub_clk;
      prev_sub_ <= prev_sub;
    end
  end

  // Level tracking and one-cycle strobes; strobes fire even when the event is dropped.
  always_ff @(posedge mclk) begin
    if (reset) begin
      level    <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      rise_stb <= changed & in;
      fall_stb <= changed & ~in;
      if (changed) begin
        level <= in;
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge mclk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  evt_fifo #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .mclk      (mclk),
    .reset     (reset),
    .push      (changed),
    .push_data ({in, data}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count)
  );

endmodule

// File: tb/tb_clk2strobe_fifo.sv
// Self-checking bench for clk2strobe_fifo: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_clk2strobe_fifo;

  localparam int DEPTH = 4;

  logic       mclk;
  logic       reset;
  logic       sub_clk;
  logic       in_sig;
  logic [7:0] data;
  logic       rise_stb;
  logic       fall_stb;
  logic       level;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_rise;
  logic [7:0] evt_data;
  logic [2:0] count;
  logic       overflow;
  logic       clr_ovf;

  int total;
  int bad;
  int strobe_seen;

  // Reference model state
  logic [8:0] mq[$];
  logic       m_level;
  logic       m_rise;
  logic       m_fall;
  logic       m_ovf;
  logic       h1;
  logic       h2;

  clk2strobe_fifo #(.DW(8), .DEPTH(DEPTH)) dut (
    .mclk      (mclk),
    .reset     (reset),
    .sub_clk   (sub_clk),
    .in        (in_sig),
    .data      (data),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .level     (level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_rise  (evt_rise),
    .evt_data  (evt_data),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // One mclk cycle: drive, let the edge happen, advance the model, settle at negedge.
  task automatic step(input logic r, input logic s, input logic i, input logic [7:0] d,
                      input logic rdy, input logic clr);
    logic sub_edge;
    logic ev;
    logic dropped;
    reset = r; sub_clk = s; in_sig = i; data = d; evt_ready = rdy; clr_ovf = clr;
    @(posedge mclk);
    if (r) begin
      mq.delete();
      m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_ovf = 1'b0;
      h1 = 1'b1; h2 = 1'b1;
    end else begin
      // sub_clk was seen high last edge and low the edge before: sample now
      sub_edge = h1 && !h2;
      ev = sub_edge && (i != m_level);
      dropped = 1'b0;
      if (rdy && mq.size() > 0) mq.delete(0);
      m_rise = ev && i;
      m_fall = ev && !i;
      if (ev) begin
        m_level = i;
        if (mq.size() < DEPTH) mq.push_back({i, d});
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      h2 = h1;
      h1 = s;
    end
    @(negedge mclk);
    if (rise_stb === 1'b1) strobe_seen++;
    if (fall_stb === 1'b1) strobe_seen++;
  endtask

  // A full sub_clk period: 4 cycles low, then 4 cycles high, inputs held.
  task automatic run_sub_cycle(input logic i, input logic [7:0] d, input logic rdy);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, i, d, rdy, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, i, d, rdy, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      total++;
      if (rise_stb !== 1'b0 || fall_stb !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_strobes: got %b%b expected 00", rise_stb, fall_stb);
      end
      total++;
      if (evt_valid !== 1'b0 || count !== 3'd0) begin
        bad++; $display("[TB] FAIL reset_fifo: got valid=%b count=%0d expected 0/0", evt_valid, count);
      end
      total++;
      if (level !== 1'b0 || overflow !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_level: got level=%b ovf=%b expected 0/0", level, overflow);
      end
      total++;
      if (evt_rise !== 1'b0 || evt_data !== 8'h00) begin
        bad++; $display("[TB] FAIL reset_head: got rise=%b data=%h expected 0/00", evt_rise, evt_data);
      end
    end
  endtask

  task automatic test_first_rise();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
      total++;
      if (rise_stb !== (k == 2) || fall_stb !== 1'b0) begin
        bad++; $display("[TB] FAIL rise_timing: high step %0d got rise=%b fall=%b expected %b/0",
                        k, rise_stb, fall_stb, (k == 2));
      end
    end
    total++;
    if (evt_valid !== 1'b1 || evt_rise !== 1'b1 || evt_data !== 8'hA5 || count !== 3'd1) begin
      bad++; $display("[TB] FAIL rise_event: got v=%b r=%b d=%h c=%0d expected 1/1/a5/1",
                      evt_valid, evt_rise, evt_data, count);
    end
    total++;
    if (level !== 1'b1) begin
      bad++; $display("[TB] FAIL rise_level: got %b expected 1", level);
    end
    step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    total++;
    if (evt_valid !== 1'b0 || count !== 3'd0) begin
      bad++; $display("[TB] FAIL rise_pop: got v=%b c=%0d expected 0/0", evt_valid, count);
    end
  endtask

  task automatic test_fall_midphase();
    int s0;
    s0 = strobe_seen;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    total++;
    if (strobe_seen != s0 || evt_valid !== 1'b0 || level !== 1'b1) begin
      bad++; $display("[TB] FAIL fall_early: got strobes=%0d v=%b level=%b expected 0/0/1",
                      strobe_seen - s0, evt_valid, level);
    end
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
      total++;
      if (fall_stb !== (k == 2) || rise_stb !== 1'b0) begin
        bad++; $display("[TB] FAIL fall_timing: high step %0d got fall=%b rise=%b expected %b/0",
                        k, fall_stb, rise_stb, (k == 2));
      end
    end
    total++;
    if (evt_valid !== 1'b1 || evt_rise !== 1'b0 || evt_data !== 8'h3C || strobe_seen != s0 + 1) begin
      bad++; $display("[TB] FAIL fall_event: got v=%b r=%b d=%h strobes=%0d expected 1/0/3c/1",
                      evt_valid, evt_rise, evt_data, strobe_seen - s0);
    end
    step(1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
    s0 = strobe_seen;
    for (int n = 0; n < 5; n++) run_sub_cycle(1'b0, 8'($urandom), 1'b0);
    total++;
    if (strobe_seen != s0 || count !== 3'd0 || level !== 1'b0) begin
      bad++; $display("[TB] FAIL hold_level: got strobes=%0d count=%0d level=%b expected 0/0/0",
                      strobe_seen - s0, count, level);
    end
  endtask

  task automatic test_overflow();
    int s0;
    s0 = strobe_seen;
    for (int n = 1; n <= 5; n++) run_sub_cycle(n[0], 8'(n), 1'b0);
    total++;
    if (count !== 3'd4 || overflow !== 1'b1 || strobe_seen != s0 + 5) begin
      bad++; $display("[TB] FAIL ovf_fill: got count=%0d ovf=%b strobes=%0d expected 4/1/5",
                      count, overflow, strobe_seen - s0);
    end
    total++;
    if (level !== 1'b1) begin
      bad++; $display("[TB] FAIL ovf_level: got %b expected 1", level);
    end
    for (int j = 1; j <= 4; j++) begin
      total++;
      if (evt_valid !== 1'b1 || evt_data !== 8'(j)) begin
        bad++; $display("[TB] FAIL ovf_pop_order: got v=%b d=%h expected 1/%h", evt_valid, evt_data, 8'(j));
      end
      step(1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0);
    end
    total++;
    if (count !== 3'd0 || overflow !== 1'b1) begin
      bad++; $display("[TB] FAIL ovf_drained: got count=%0d ovf=%b expected 0/1", count, overflow);
    end
    step(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    run_sub_cycle(1'b0, 8'h10, 1'b0);
    run_sub_cycle(1'b1, 8'h11, 1'b0);
    run_sub_cycle(1'b0, 8'h12, 1'b0);
    run_sub_cycle(1'b1, 8'h13, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 8'h14, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h14, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h14, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h14, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h14, 1'b0, 1'b0);
    total++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      bad++; $display("[TB] FAIL full_pop_count: got count=%0d ovf=%b expected 4/0", count, overflow);
    end
    for (int j = 1; j <= 4; j++) begin
      total++;
      if (evt_data !== 8'(8'h10 + j)) begin
        bad++; $display("[TB] FAIL full_pop_order: got %h expected %h", evt_data, 8'(8'h10 + j));
      end
      step(1'b0, 1'b0, 1'b0, 8'h14, 1'b1, 1'b0);
    end
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL full_pop_empty: got v=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_reset_mid();
    run_sub_cycle(1'b1, 8'h31, 1'b0);
    run_sub_cycle(1'b0, 8'h32, 1'b0);
    run_sub_cycle(1'b1, 8'h33, 1'b0);
    total++;
    if (count !== 3'd3) begin
      bad++; $display("[TB] FAIL mid_fill: got count=%0d expected 3", count);
    end
    step(1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    total++;
    if (count !== 3'd0 || evt_valid !== 1'b0 || level !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_reset: got c=%0d v=%b level=%b expected 0/0/0", count, evt_valid, level);
    end
    run_sub_cycle(1'b1, 8'h41, 1'b0);
    total++;
    if (count !== 3'd1 || evt_rise !== 1'b1 || evt_data !== 8'h41 || level !== 1'b1) begin
      bad++; $display("[TB] FAIL mid_first_rise: got c=%0d r=%b d=%h level=%b expected 1/1/41/1",
                      count, evt_rise, evt_data, level);
    end
  endtask

  task automatic test_random();
    logic s;
    logic i;
    logic r;
    int   len;
    s = 1'b0;
    i = level;
    for (int p = 0; p < 120; p++) begin
      len = $urandom_range(2, 5);
      for (int k = 0; k < len; k++) begin
        r = ($urandom_range(0, 99) < 2);
        if ($urandom_range(0, 3) == 0) i = ~i;
        step(r, s, i, 8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
        total++;
        if (rise_stb !== m_rise || fall_stb !== m_fall) begin
          bad++; $display("[TB] FAIL rand_strobes: got %b%b expected %b%b", rise_stb, fall_stb, m_rise, m_fall);
        end
        total++;
        if (level !== m_level || overflow !== m_ovf) begin
          bad++; $display("[TB] FAIL rand_flags: got level=%b ovf=%b expected %b/%b", level, overflow, m_level, m_ovf);
        end
        total++;
        if (count !== 3'(mq.size()) || evt_valid !== (mq.size() > 0)) begin
          bad++; $display("[TB] FAIL rand_count: got c=%0d v=%b expected %0d", count, evt_valid, mq.size());
        end
        if (mq.size() > 0) begin
          total++;
          if ({evt_rise, evt_data} !== mq[0]) begin
            bad++; $display("[TB] FAIL rand_head: got %h expected %h", {evt_rise, evt_data}, mq[0]);
          end
        end
      end
      s = ~s;
    end
  endtask

  initial begin
    total = 0; bad = 0; strobe_seen = 0;
    reset = 1'b1; sub_clk = 1'b1; in_sig = 1'b0; data = 8'h00; evt_ready = 1'b0; clr_ovf = 1'b0;
    @(negedge mclk);
    test_reset();
    test_first_rise();
    test_fall_midphase();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
